cpu_mem_lsu: RTL and testbench

CPU_MEM_LSU -- requirements
Module: cpu_mem_lsu

---
 rtl/cpu_mem_lsu_pkg.sv | 67 ++++++
 rtl/cpu_mem_align.sv | 49 ++++
 rtl/cpu_mem_lsu.sv | 196 +++++++++++++++++++
 tb/tb_cpu_mem_lsu.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op and writeback-source
// encodings, FSM state enum and the lane-selection helpers.
package cpu_mem_lsu_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_LD   = 4'd6,
        OP_SB   = 4'd8,
        OP_SH   = 4'd9,
        OP_SW   = 4'd10,
        OP_SD   = 4'd11
    } mem_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_DM  = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LD};
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            OP_LW, OP_SW:         return 2'd2;
            default:              return 2'd3;
        endcase
    endfunction

    function automatic logic op_signed(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW};
    endfunction

    // Byte-offset bits that must be zero for an aligned access of this size
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // A lane belongs to the access when it sits in the same size-aligned group as the offset
    function automatic logic lane_sel(input int lane, input logic [2:0] off, input logic [1:0] sz);
        return (lane >> sz) == (int'(off) >> sz);
    endfunction

endpackage

// File: rtl/cpu_mem_align.sv
// Combinational lane steering: store replication and byte enables, load lane
// extraction with sign/zero extension.
module cpu_mem_align
    import cpu_mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [3:0]          op,
    input  logic [OFF_W-1:0]    off,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   load_data
);

    localparam int NB = DATA_W / 8;

    logic [1:0]        sz;
    logic [DATA_W-1:0] shifted;

    assign sz      = op_size(op);
    assign shifted = rdata >> {off, 3'b000};

    // Store side: replicate the operand across every lane, enable only the addressed ones
    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++) be[i] = lane_sel(i, 3'(off), sz);
        case (sz)
            2'd0:    wdata = {NB{store_data[7:0]}};
            2'd1:    wdata = {(NB/2){store_data[15:0]}};
            2'd2:    wdata = {(NB/4){store_data[31:0]}};
            default: wdata = store_data;
        endcase
    end

    // Load side: addressed lane is already at bit 0, extend to the full width
    always_comb begin
        load_data = shifted;
        case (sz)
            2'd0: load_data = op_signed(op) ? DATA_W'($signed(shifted[7:0]))  : DATA_W'(shifted[7:0]);
            2'd1: load_data = op_signed(op) ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0]);
            2'd2: load_data = op_signed(op) ? DATA_W'($signed(shifted[31:0])) : DATA_W'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/cpu_mem_lsu.sv
// MEM stage load/store unit: request FSM, stall generation and WB registers.
// Optional build macro CPU_MEM_LSU_MISALIGN_TRAP_EN: misaligned half/word
// accesses are trapped (no request, misalign flag) instead of being aligned down.
//
// state   | meaning
// ST_IDLE | no request outstanding; a new memory op may issue this cycle
// ST_WAIT | request issued, holding captured request until dm_ack
module cpu_mem_lsu
    import cpu_mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                in_valid,
    input  logic [31:0]         current_pc,
    input  logic [3:0]          mem_op,
    input  logic [1:0]          wb_sel,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   store_data,
    input  logic                reg_write_en,
    input  logic [4:0]          reg_write_num,
    output logic                stall,
    output logic                dm_req,
    output logic                dm_we,
    output logic [DATA_W/8-1:0] dm_be,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    input  logic                dm_ack,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic                out_valid,
    output logic                reg_write_en_mem,
    output logic [4:0]          reg_write_num_mem,
    output logic [DATA_W-1:0]   reg_write_data,
    output logic                misalign,
    output logic [4:0]          reg_write_num_realtime
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state_q, state_d;
    logic [2:0]        mask_full;
    logic [OFF_W-1:0]  off_raw, low_mask, off_al;
    logic              is_mem, trap, issue, complete;

    logic              cap_we;
    logic [NB-1:0]     cap_be;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [3:0]        cap_op;
    logic [OFF_W-1:0]  cap_off;

    logic [3:0]        al_op;
    logic [OFF_W-1:0]  al_off;
    logic [NB-1:0]     al_be;
    logic [DATA_W-1:0] al_wdata, al_load;

    assign mask_full = size_mask(op_size(mem_op));
    assign low_mask  = mask_full[OFF_W-1:0];
    assign off_raw   = alu_result[OFF_W-1:0];
    assign off_al    = off_raw & ~low_mask;
    assign is_mem    = in_valid && (op_is_load(mem_op) || op_is_store(mem_op));

`ifdef CPU_MEM_LSU_MISALIGN_TRAP_EN
    assign trap = is_mem && (|(off_raw & low_mask));
`else
    assign trap = 1'b0;
`endif

    assign issue = is_mem && !trap;

    // In WAIT the load is steered by the captured op/offset, not the live inputs
    assign al_op  = (state_q == ST_WAIT) ? cap_op  : mem_op;
    assign al_off = (state_q == ST_WAIT) ? cap_off : off_al;

    cpu_mem_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
        .op         (al_op),
        .off        (al_off),
        .store_data (store_data),
        .rdata      (dm_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    assign reg_write_num_realtime = reg_write_num;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and request outputs; everything is forced quiet while clr_n is low
    always_comb begin
        state_d  = state_q;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_be    = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        stall    = 1'b0;
        complete = 1'b0;
        if (clr_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        dm_req   = 1'b1;
                        dm_we    = op_is_store(mem_op);
                        dm_be    = al_be;
                        dm_addr  = alu_result[ADDR_W+OFF_W-1:OFF_W];
                        dm_wdata = al_wdata;
                        if (dm_ack) complete = 1'b1;
                        else begin
                            stall   = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end else begin
                        complete = 1'b1;
                    end
                end
                ST_WAIT: begin
                    dm_req   = 1'b1;
                    dm_we    = cap_we;
                    dm_be    = cap_be;
                    dm_addr  = cap_addr;
                    dm_wdata = cap_wdata;
                    if (dm_ack) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Capture the request on the cycle it issues without an ack
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cap_we    <= 1'b0;
            cap_be    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_op    <= '0;
            cap_off   <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_WAIT) begin
            cap_we    <= dm_we;
            cap_be    <= dm_be;
            cap_addr  <= dm_addr;
            cap_wdata <= dm_wdata;
            cap_op    <= mem_op;
            cap_off   <= off_al;
        end
    end

`ifdef CPU_MEM_LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    // Misalignment flag follows the WB registers: load on completion, hold while stalled
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)        misalign_q <= 1'b0;
        else if (complete) misalign_q <= trap;
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // WB registers: load on completion, bubble out_valid while stalled
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_valid         <= 1'b0;
            reg_write_en_mem  <= 1'b0;
            reg_write_num_mem <= '0;
            reg_write_data    <= '0;
        end else if (complete) begin
            out_valid         <= in_valid;
            reg_write_en_mem  <= reg_write_en && in_valid && !trap;
            reg_write_num_mem <= reg_write_num;
            case (wb_sel)
                WB_DM:   reg_write_data <= al_load;
                WB_PC:   reg_write_data <= DATA_W'(current_pc + 32'd1);
                default: reg_write_data <= alu_result;
            endcase
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_mem_lsu.sv
// Directed bench for cpu_mem_lsu (DATA_W=32, ADDR_W=8) with hand-computed expectations.
module tb_cpu_mem_lsu;
    import cpu_mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        in_valid;
    logic [31:0] current_pc;
    logic [3:0]  mem_op;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        reg_write_en;
    logic [4:0]  reg_write_num;
    logic        stall, dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        out_valid, reg_write_en_mem, misalign;
    logic [4:0]  reg_write_num_mem, reg_write_num_realtime;
    logic [31:0] reg_write_data;

    int n_chk = 0;
    int n_err = 0;

    cpu_mem_lsu #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk                    (clk),
        .clr_n                  (clr_n),
        .in_valid               (in_valid),
        .current_pc             (current_pc),
        .mem_op                 (mem_op),
        .wb_sel                 (wb_sel),
        .alu_result             (alu_result),
        .store_data             (store_data),
        .reg_write_en           (reg_write_en),
        .reg_write_num          (reg_write_num),
        .stall                  (stall),
        .dm_req                 (dm_req),
        .dm_we                  (dm_we),
        .dm_be                  (dm_be),
        .dm_addr                (dm_addr),
        .dm_wdata               (dm_wdata),
        .dm_ack                 (dm_ack),
        .dm_rdata               (dm_rdata),
        .out_valid              (out_valid),
        .reg_write_en_mem       (reg_write_en_mem),
        .reg_write_num_mem      (reg_write_num_mem),
        .reg_write_data         (reg_write_data),
        .misalign               (misalign),
        .reg_write_num_realtime (reg_write_num_realtime)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic [3:0] op, input logic [1:0] wb,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input logic rwe, input logic [4:0] num, input logic [31:0] pc);
        in_valid      = v;
        mem_op        = op;
        wb_sel        = wb;
        alu_result    = alu;
        store_data    = sd;
        reg_write_en  = rwe;
        reg_write_num = num;
        current_pc    = pc;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        clr_n = 1'b0;
        dm_ack = 1'b0;
        dm_rdata = '0;
        set_op(1'b1, OP_LW, WB_DM, 32'h10, 32'h0, 1'b1, 5'd3, 32'h0);
        after_edge();
        chk("rst_dm_req", dm_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rwe", reg_write_en_mem, 0);
        chk("rst_data", reg_write_data, 0);
        chk("rst_misalign", misalign, 0);

        // SW 0x10, ack same cycle; first edge after release is operational
        @(negedge clk);
        clr_n = 1'b1;
        set_op(1'b1, OP_SW, WB_ALU, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        dm_ack = 1'b1;
        #1;
        chk("sw_req", dm_req, 1);
        chk("sw_we", dm_we, 1);
        chk("sw_addr", dm_addr, 4);
        chk("sw_be", dm_be, 4'b1111);
        chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
        chk("sw_stall", stall, 0);
        after_edge();
        chk("sw_out_valid", out_valid, 1);
        chk("sw_rwe", reg_write_en_mem, 0);

        // LB 0x13, ack after 3 stall cycles
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_op(1'b1, OP_LB, WB_DM, 32'h13, 32'h0, 1'b1, 5'd5, 32'h0);
            dm_rdata = 32'h80000000;
            dm_ack = (k == 3);
            #1;
            chk("lb_stall", stall, (k < 3) ? 1 : 0);
            chk("lb_req", dm_req, 1);
            chk("lb_we", dm_we, 0);
            chk("lb_addr", dm_addr, 4);
            after_edge();
            if (k < 3) chk("lb_bubble", out_valid, 0);
        end
        chk("lb_out_valid", out_valid, 1);
        chk("lb_data", reg_write_data, 32'hFFFFFF80);
        chk("lb_rwe", reg_write_en_mem, 1);
        chk("lb_num", reg_write_num_mem, 5);

        // LBU same lane, ack same cycle
        @(negedge clk);
        set_op(1'b1, OP_LBU, WB_DM, 32'h13, 32'h0, 1'b1, 5'd6, 32'h0);
        dm_ack = 1'b1;
        #1;
        chk("lbu_stall", stall, 0);
        after_edge();
        chk("lbu_data", reg_write_data, 32'h00000080);

        // SH 0x06 with one wait cycle; live inputs disturbed while waiting
        @(negedge clk);
        set_op(1'b1, OP_SH, WB_ALU, 32'h06, 32'h1234, 1'b0, 5'd0, 32'h0);
        dm_ack = 1'b0;
        #1;
        chk("sh_be", dm_be, 4'b1100);
        chk("sh_wdata", dm_wdata, 32'h12341234);
        chk("sh_stall", stall, 1);
        after_edge();
        @(negedge clk);
        alu_result = 32'h0;
        store_data = 32'h0;
        dm_ack = 1'b1;
        #1;
        chk("sh_wait_addr", dm_addr, 1);
        chk("sh_wait_be", dm_be, 4'b1100);
        chk("sh_wait_wdata", dm_wdata, 32'h12341234);
        chk("sh_wait_we", dm_we, 1);
        chk("sh_wait_stall", stall, 0);
        after_edge();
        chk("sh_out_valid", out_valid, 1);

        // LH 0x06 sign-extends upper half
        @(negedge clk);
        set_op(1'b1, OP_LH, WB_DM, 32'h06, 32'h0, 1'b1, 5'd7, 32'h0);
        dm_rdata = 32'hABCD0000;
        dm_ack = 1'b1;
        after_edge();
        chk("lh_data", reg_write_data, 32'hFFFFABCD);

        // PC writeback, no memory op
        @(negedge clk);
        set_op(1'b1, OP_NONE, WB_PC, 32'h0, 32'h0, 1'b1, 5'd31, 32'h40);
        dm_ack = 1'b0;
        #1;
        chk("pc_req", dm_req, 0);
        chk("pc_stall", stall, 0);
        chk("pc_realtime", reg_write_num_realtime, 31);
        after_edge();
        chk("pc_data", reg_write_data, 32'h41);
        chk("pc_num", reg_write_num_mem, 31);

        // in_valid low with a load op: no request, invalid WB; stray ack ignored
        @(negedge clk);
        set_op(1'b0, OP_LW, WB_DM, 32'h20, 32'h0, 1'b1, 5'd9, 32'h0);
        dm_ack = 1'b1;
        #1;
        chk("inv_req", dm_req, 0);
        after_edge();
        chk("inv_out_valid", out_valid, 0);
        chk("inv_rwe", reg_write_en_mem, 0);

        // ALU writeback to leave known nonzero WB state
        @(negedge clk);
        set_op(1'b1, OP_NONE, WB_ALU, 32'hCAFE, 32'h0, 1'b1, 5'd2, 32'h0);
        dm_ack = 1'b0;
        after_edge();
        chk("alu_data", reg_write_data, 32'hCAFE);
        chk("alu_out_valid", out_valid, 1);

        // Reset while waiting: outputs drop immediately
        @(negedge clk);
        set_op(1'b1, OP_LW, WB_DM, 32'h20, 32'h0, 1'b1, 5'd4, 32'h0);
        dm_ack = 1'b0;
        #1;
        chk("wr_stall", stall, 1);
        after_edge();
        #2;
        clr_n = 1'b0;
        #1;
        chk("wr_rst_req", dm_req, 0);
        chk("wr_rst_stall", stall, 0);
        chk("wr_rst_out_valid", out_valid, 0);
        chk("wr_rst_data", reg_write_data, 0);
        @(negedge clk);
        clr_n = 1'b1;
        set_op(1'b1, OP_LW, WB_DM, 32'h0C, 32'h0, 1'b1, 5'd8, 32'h0);
        dm_rdata = 32'h0BADF00D;
        dm_ack = 1'b1;
        #1;
        chk("post_rst_req", dm_req, 1);
        chk("post_rst_addr", dm_addr, 3);
        chk("post_rst_stall", stall, 0);
        after_edge();
        chk("post_rst_data", reg_write_data, 32'h0BADF00D);

        // Misaligned LW 0x02
        @(negedge clk);
        set_op(1'b1, OP_LW, WB_DM, 32'h02, 32'h0, 1'b1, 5'd10, 32'h0);
        dm_rdata = 32'h11223344;
        dm_ack = 1'b1;
        #1;
`ifdef CPU_MEM_LSU_MISALIGN_TRAP_EN
        chk("mis_req", dm_req, 0);
        chk("mis_stall", stall, 0);
        after_edge();
        chk("mis_flag", misalign, 1);
        chk("mis_rwe", reg_write_en_mem, 0);
        chk("mis_out_valid", out_valid, 1);
`else
        chk("mis_req", dm_req, 1);
        chk("mis_addr", dm_addr, 0);
        chk("mis_be", dm_be, 4'b1111);
        after_edge();
        chk("mis_flag", misalign, 0);
        chk("mis_data", reg_write_data, 32'h11223344);
        chk("mis_rwe", reg_write_en_mem, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
